// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO and models the multi-cycle
// latency of MULT/MULTU/DIV/DIVU with a busy countdown.
module md_unit #(
    parameter int unsigned MULT_DELAY = 5,
    parameter int unsigned DIV_DELAY  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MULT,
    input  logic        MULTU,
    input  logic        DIV,
    input  logic        DIVU,
    input  logic        MFHI,
    input  logic        MFLO,
    input  logic        MTHI,
    input  logic        MTLO,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_DELAY = (MULT_DELAY > DIV_DELAY) ? MULT_DELAY : DIV_DELAY;
    localparam int unsigned CNT_W     = $clog2(MAX_DELAY + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Result captured at start and held until the countdown expires.
    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } md_res_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    md_res_t           pend;
    md_res_t           res;

    logic              start_op;
    logic              is_mul;
    logic              commit;
    logic              hi_wr_en;
    logic              lo_wr_en;

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;

    logic [DATA_W-1:0]  divisor_u;
    logic [DATA_W-1:0]  q_u;
    logic [DATA_W-1:0]  r_u;
    logic [DATA_W-1:0]  a_mag;
    logic [DATA_W-1:0]  b_mag;
    logic [DATA_W-1:0]  q_mag;
    logic [DATA_W-1:0]  r_mag;
    logic [DATA_W-1:0]  q_s;
    logic [DATA_W-1:0]  r_s;
    logic               b_nz;

    assign start_op = MULT | MULTU | DIV | DIVU;
    assign is_mul   = MULT | MULTU;

    // Full-width products.
    always_comb begin
        a_sx   = {{DATA_W{A[DATA_W-1]}}, A};
        b_sx   = {{DATA_W{B[DATA_W-1]}}, B};
        prod_s = 64'(a_sx * b_sx);
        prod_u = 64'({32'd0, A} * {32'd0, B});
    end

    // Signed division on magnitudes; the 0x80000000 / -1 case falls out as
    // quotient 0x80000000, remainder 0 without special handling.
    always_comb begin
        b_nz      = (B != 32'd0);
        divisor_u = b_nz ? B : 32'd1;
        q_u       = A / divisor_u;
        r_u       = A % divisor_u;
        a_mag     = A[DATA_W-1] ? 32'(-A) : A;
        b_mag     = B[DATA_W-1] ? 32'(-B) : divisor_u;
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        q_s       = (A[DATA_W-1] ^ B[DATA_W-1]) ? 32'(-q_mag) : q_mag;
        r_s       = A[DATA_W-1] ? 32'(-r_mag) : r_mag;
    end

    always_comb begin
        res.wr = 1'b1;
        res.hi = 32'd0;
        res.lo = 32'd0;
        if (MULT) begin
            res.hi = prod_s[63:32];
            res.lo = prod_s[31:0];
        end else if (MULTU) begin
            res.hi = prod_u[63:32];
            res.lo = prod_u[31:0];
        end else if (DIV) begin
            res.wr = b_nz;
            res.hi = r_s;
            res.lo = q_s;
        end else if (DIVU) begin
            res.wr = b_nz;
            res.hi = r_u;
            res.lo = q_u;
        end
    end

    // State register, countdown and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (Start) begin
                pend <= res;
            end
            if (commit) begin
                if (pend.wr) begin
                    HI <= pend.hi;
                    LO <= pend.lo;
                end
            end else begin
                if (hi_wr_en) begin
                    HI <= A;
                end
                if (lo_wr_en) begin
                    LO <= A;
                end
            end
        end
    end

    // Next state and countdown.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start_op) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = is_mul ? CNT_W'(MULT_DELAY) : CNT_W'(DIV_DELAY);
                end
            end
            S_BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs and write enables.
    always_comb begin
        Busy     = 1'b0;
        Start    = 1'b0;
        commit   = 1'b0;
        hi_wr_en = 1'b0;
        lo_wr_en = 1'b0;
        MDOut    = 32'd0;
        case (state)
            S_IDLE: begin
                Start    = start_op;
                hi_wr_en = MTHI;
                lo_wr_en = MTLO;
            end
            S_BUSY: begin
                Busy   = 1'b1;
                commit = (cnt == CNT_W'(1));
            end
            default: ;
        endcase
        if (MFHI) begin
            MDOut = HI;
        end else if (MFLO) begin
            MDOut = LO;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomized bench for md_unit against a cycle-count reference model of HI/LO.
module tb_md_unit;

    typedef longint unsigned u64_t;

    localparam int OP_NOP   = 0;
    localparam int OP_MULT  = 1;
    localparam int OP_MULTU = 2;
    localparam int OP_DIV   = 3;
    localparam int OP_DIVU  = 4;
    localparam int OP_MTHI  = 5;
    localparam int OP_MTLO  = 6;

    localparam int RD_NONE = 0;
    localparam int RD_HI   = 1;
    localparam int RD_LO   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic        MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO;
    logic        Start, Busy;
    logic [31:0] HI, LO, MDOut;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural HI/LO plus a pending result that lands
    // when the cycle counter reaches its completion cycle.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [31:0] p_hi, p_lo;
    bit          p_wr;
    bit          m_busy = 1'b0;
    longint      cyc = 0;
    longint      done_at = 0;

    md_unit #(.MULT_DELAY(5), .DIV_DELAY(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B),
        .MULT(MULT), .MULTU(MULTU), .DIV(DIV), .DIVU(DIVU),
        .MFHI(MFHI), .MFLO(MFLO), .MTHI(MTHI), .MTLO(MTLO),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit is_start(input int op);
        return op >= OP_MULT && op <= OP_DIVU;
    endfunction

    task automatic compute(input int op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        u64_t   pu;
        int     q, r;
        p_wr = 1'b1;
        case (op)
            OP_MULT: begin
                p = longint'(int'(a)) * longint'(int'(b));
                p_hi = p[63:32]; p_lo = p[31:0];
            end
            OP_MULTU: begin
                pu = u64_t'(a) * u64_t'(b);
                p_hi = pu[63:32]; p_lo = pu[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) p_wr = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    p_lo = 32'h8000_0000; p_hi = 32'd0;
                end else begin
                    q = int'(a) / int'(b);
                    r = int'(a) % int'(b);
                    p_lo = q; p_hi = r;
                end
            end
            default: begin
                if (b == 32'd0) p_wr = 1'b0;
                else begin
                    p_lo = a / b; p_hi = a % b;
                end
            end
        endcase
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cycle(input int op, input logic [31:0] a, input logic [31:0] b,
                         input int rd, input logic rst);
        logic [31:0] exp_md;
        reset = rst; A = a; B = b;
        MULT = (op == OP_MULT); MULTU = (op == OP_MULTU);
        DIV = (op == OP_DIV); DIVU = (op == OP_DIVU);
        MTHI = (op == OP_MTHI); MTLO = (op == OP_MTLO);
        MFHI = (rd == RD_HI); MFLO = (rd == RD_LO);
        @(negedge clk);
        exp_md = (rd == RD_HI) ? m_hi : (rd == RD_LO) ? m_lo : 32'd0;
        check("busy",  32'(Busy),  32'(m_busy));
        check("start", 32'(Start), 32'(is_start(op) && !m_busy));
        check("hi",    HI, m_hi);
        check("lo",    LO, m_lo);
        check("mdout", MDOut, exp_md);
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0;
        end else if (m_busy) begin
            if (cyc == done_at) begin
                if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
                m_busy = 1'b0;
            end
        end else if (is_start(op)) begin
            compute(op, a, b);
            m_busy  = 1'b1;
            done_at = cyc + ((op <= OP_MULTU) ? 5 : 10);
        end else if (op == OP_MTHI) m_hi = a;
        else if (op == OP_MTLO) m_lo = a;
        #1;
    endtask

    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input int n_idle);
        cycle(op, a, b, RD_NONE, 1'b0);
        for (int i = 0; i < n_idle; i++) cycle(OP_NOP, 32'd0, 32'd0, i % 3, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    initial begin
        reset = 1'b1; A = '0; B = '0;
        {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO} = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle(OP_NOP, 32'd0, 32'd0, RD_NONE, 1'b1);
        check("reset_hi", HI, 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);
        cycle(OP_NOP, 32'd0, 32'd0, RD_LO, 1'b0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 10);
        check("divu_lo", LO, 32'h7FFF_FFFC);
        check("divu_hi", HI, 32'd1);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);

        cycle(OP_NOP, 32'd0, 32'd0, RD_NONE, 1'b1);
        run_op(OP_MTHI, 32'h1234_5678, 32'd0, 0);
        run_op(OP_DIV, 32'd99, 32'd0, 10);
        check("div0_hi", HI, 32'h1234_5678);
        check("div0_lo", LO, 32'd0);

        // Start-type and MT ops while busy are dropped.
        cycle(OP_MULT, 32'd7, 32'd6, RD_NONE, 1'b0);
        cycle(OP_NOP, 32'd0, 32'd0, RD_NONE, 1'b0);
        cycle(OP_MTLO, 32'h0000_AAAA, 32'd0, RD_NONE, 1'b0);
        cycle(OP_MULT, 32'd3, 32'd3, RD_NONE, 1'b0);
        run_op(OP_NOP, 32'd0, 32'd0, 2);
        check("ignore_lo", LO, 32'd42);
        check("ignore_hi", HI, 32'd0);

        // Reset mid-operation aborts the pending write.
        cycle(OP_MTHI, 32'h5555_0000, 32'd0, RD_NONE, 1'b0);
        cycle(OP_MULT, 32'd7, 32'd6, RD_NONE, 1'b0);
        cycle(OP_NOP, 32'd0, 32'd0, RD_NONE, 1'b0);
        cycle(OP_NOP, 32'd0, 32'd0, RD_NONE, 1'b0);
        cycle(OP_NOP, 32'd0, 32'd0, RD_NONE, 1'b1);
        check("abort_busy", 32'(Busy), 32'd0);
        run_op(OP_NOP, 32'd0, 32'd0, 6);
        check("abort_lo", LO, 32'd0);
        check("abort_hi", HI, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int op;
            op = (m_busy && $urandom_range(0, 5) != 0) ? OP_NOP : int'($urandom_range(0, 6));
            cycle(op, pick_operand(), pick_operand(), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 149) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
